// File: rtl/multicycle_control_unit.sv
// LEGv8 multi-cycle control unit: latches the instruction in FETCH, drives the
// decoded 30-bit control word and 64-bit constant in EXEC, finishes BL in LINK.
module multicycle_control_unit #(
  parameter int unsigned LINK_REG = 30,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [4:0]  status,
  output logic [29:0] control_word,
  output logic [63:0] constant,
  output logic        halted
);

  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);
  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_ABS  = 2'b10;
  localparam logic [1:0] PS_REL  = 2'b11;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_EOR = 5'b01100;
  localparam logic [4:0] FS_LSL = 5'b10000;
  localparam logic [4:0] FS_LSR = 5'b10100;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_LINK, S_HALT} state_e;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDS, OP_SUBS, OP_LSL, OP_LSR,
    OP_LDUR, OP_STUR, OP_BR, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI,
    OP_ADDIS, OP_SUBIS, OP_MOVZ, OP_CBZ, OP_CBNZ, OP_BCOND, OP_B, OP_BL, OP_BAD
  } op_e;

  // Longest opcode field wins; shorter prefixes are only tried when nothing longer matched.
  function automatic op_e decode_op(input logic [31:0] ir);
    op_e op;
    case (ir[31:21])
      11'b10001011000: op = OP_ADD;
      11'b11001011000: op = OP_SUB;
      11'b10001010000: op = OP_AND;
      11'b10101010000: op = OP_ORR;
      11'b11001010000: op = OP_EOR;
      11'b10101011000: op = OP_ADDS;
      11'b11101011000: op = OP_SUBS;
      11'b11010011011: op = OP_LSL;
      11'b11010011010: op = OP_LSR;
      11'b11111000010: op = OP_LDUR;
      11'b11111000000: op = OP_STUR;
      11'b11010110000: op = OP_BR;
      default:         op = OP_BAD;
    endcase
    if (op == OP_BAD) begin
      case (ir[31:22])
        10'b1001000100: op = OP_ADDI;
        10'b1101000100: op = OP_SUBI;
        10'b1001001000: op = OP_ANDI;
        10'b1011001000: op = OP_ORRI;
        10'b1101001000: op = OP_EORI;
        10'b1011000100: op = OP_ADDIS;
        10'b1111000100: op = OP_SUBIS;
        default: ;
      endcase
    end
    if (op == OP_BAD && ir[31:23] == 9'b110100101) op = OP_MOVZ;
    if (op == OP_BAD) begin
      case (ir[31:24])
        8'b10110100: op = OP_CBZ;
        8'b10110101: op = OP_CBNZ;
        8'b01010100: op = OP_BCOND;
        default: ;
      endcase
    end
    if (op == OP_BAD) begin
      case (ir[31:26])
        6'b000101: op = OP_B;
        6'b100101: op = OP_BL;
        default: ;
      endcase
    end
    return op;
  endfunction

  function automatic logic [4:0] alu_fs(input op_e op);
    case (op)
      OP_ADD, OP_ADDS, OP_ADDI, OP_ADDIS: return FS_ADD;
      OP_SUB, OP_SUBS, OP_SUBI, OP_SUBIS: return FS_SUB;
      OP_ORR, OP_ORRI:                    return FS_ORR;
      OP_EOR, OP_EORI:                    return FS_EOR;
      OP_LSL:                             return FS_LSL;
      OP_LSR:                             return FS_LSR;
      default:                            return FS_AND;
    endcase
  endfunction

  function automatic logic sets_flags(input op_e op);
    return (op == OP_ADDS) || (op == OP_SUBS) || (op == OP_ADDIS) || (op == OP_SUBIS);
  endfunction

  // flags = {V, C, N, Z}; code 0xF behaves as AL.
  function automatic logic cond_true(input logic [3:0] code, input logic [3:0] flags);
    logic v, c, n, z;
    {v, c, n, z} = flags;
    case (code)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return c;
      4'h3:    return !c;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return c && !z;
      4'h9:    return !(c && !z);
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  op_e         op;

  logic        en_pc, en_mem, en_alu, pcsel, bsel, sl, wm, wr;
  logic [1:0]  ps;
  logic [4:0]  fs, sb, sa, da;
  logic [63:0] const_w;
  logic [63:0] br26_off, br19_off;

  assign op       = decode_op(ir_q);
  assign br26_off = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};
  assign br19_off = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) ir_q <= instruction;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (op == OP_BAD)     state_d = S_HALT;
        else if (op == OP_BL) state_d = S_LINK;
        else                  state_d = S_FETCH;
      end
      S_LINK:  state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    en_pc   = 1'b0;
    en_mem  = 1'b0;
    en_alu  = 1'b0;
    pcsel   = 1'b0;
    bsel    = 1'b0;
    sl      = 1'b0;
    wm      = 1'b0;
    wr      = 1'b0;
    ps      = PS_HOLD;
    fs      = FS_AND;
    sb      = '0;
    sa      = '0;
    da      = '0;
    const_w = '0;
    case (state_q)
      S_EXEC: begin
        ps = PS_INC;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_ADDS, OP_SUBS, OP_LSL, OP_LSR: begin
            sa     = ir_q[9:5];
            sb     = ir_q[20:16];
            da     = ir_q[4:0];
            en_alu = 1'b1;
            wr     = 1'b1;
            fs     = alu_fs(op);
            sl     = sets_flags(op);
            if (op == OP_LSL || op == OP_LSR) begin
              bsel    = 1'b1;
              const_w = {58'd0, ir_q[15:10]};
            end
          end
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI, OP_ADDIS, OP_SUBIS: begin
            sa      = ir_q[9:5];
            da      = ir_q[4:0];
            en_alu  = 1'b1;
            wr      = 1'b1;
            bsel    = 1'b1;
            fs      = alu_fs(op);
            sl      = sets_flags(op);
            const_w = {52'd0, ir_q[21:10]};
          end
          OP_MOVZ: begin
            sa      = ZERO_IDX;
            da      = ir_q[4:0];
            fs      = FS_ORR;
            bsel    = 1'b1;
            en_alu  = 1'b1;
            wr      = 1'b1;
            const_w = {48'd0, ir_q[20:5]} << {ir_q[22:21], 4'b0000};
          end
          OP_LDUR, OP_STUR: begin
            sa      = ir_q[9:5];
            fs      = FS_ADD;
            bsel    = 1'b1;
            const_w = {{55{ir_q[20]}}, ir_q[20:12]};
            if (op == OP_LDUR) begin
              en_mem = 1'b1;
              wr     = 1'b1;
              da     = ir_q[4:0];
            end else begin
              sb = ir_q[4:0];
              wm = 1'b1;
            end
          end
          OP_B: begin
            pcsel   = 1'b1;
            ps      = PS_REL;
            const_w = br26_off;
          end
          OP_CBZ, OP_CBNZ: begin
            sa      = ZERO_IDX;
            sb      = ir_q[4:0];
            fs      = FS_ORR;
            pcsel   = 1'b1;
            const_w = br19_off;
            ps      = (status[0] == (op == OP_CBZ)) ? PS_REL : PS_INC;
          end
          OP_BCOND: begin
            pcsel   = 1'b1;
            const_w = br19_off;
            ps      = cond_true(ir_q[3:0], status[4:1]) ? PS_REL : PS_INC;
          end
          OP_BR: begin
            sa = ir_q[9:5];
            ps = PS_ABS;
          end
          OP_BL: begin
            en_pc = 1'b1;
            wr    = 1'b1;
            da    = LINK_IDX;
            ps    = PS_HOLD;
          end
          default: ps = PS_HOLD;
        endcase
      end
      // Second half of BL: the return address was written in EXEC, now take the branch.
      S_LINK: begin
        pcsel   = 1'b1;
        ps      = PS_REL;
        const_w = br26_off;
      end
      default: ;
    endcase
  end

  assign control_word = {en_pc, en_mem, en_alu, pcsel, bsel, sl, wm, wr, ps, fs, sb, sa, da};
  assign constant     = const_w;
  assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with an instruction-level reference model.
module tb_multicycle_control_unit;

  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  status;
  logic [29:0] control_word;
  logic [63:0] constant;
  logic        halted;

  multicycle_control_unit #(.LINK_REG(30), .ZERO_REG(31)) dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .status       (status),
    .control_word (control_word),
    .constant     (constant),
    .halted       (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam int I_BAD = 0,  I_ADD = 1,   I_SUB = 2,    I_AND = 3,    I_ORR = 4,  I_EOR = 5;
  localparam int I_ADDS = 6, I_SUBS = 7,  I_LSL = 8,    I_LSR = 9,    I_LDUR = 10, I_STUR = 11;
  localparam int I_BR = 12,  I_ADDI = 13, I_SUBI = 14,  I_ANDI = 15,  I_ORRI = 16, I_EORI = 17;
  localparam int I_ADDIS = 18, I_SUBIS = 19, I_MOVZ = 20, I_CBZ = 21, I_CBNZ = 22, I_BCOND = 23;
  localparam int I_B = 24,   I_BL = 25;

  typedef struct {
    int len;
    int pat;
    int id;
  } rule_t;

  rule_t rules[$];

  int          checks = 0;
  int          errors = 0;
  int          m_phase;
  logic [31:0] m_ir;
  bit          m_valid = 0;
  logic [29:0] s_word;
  logic [63:0] s_const;
  logic        s_halt;

  task automatic add_rule(input int len, input int pat, input int id);
    rule_t r;
    r.len = len;
    r.pat = pat;
    r.id  = id;
    rules.push_back(r);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_decode(input logic [31:0] ins);
    int id;
    id = I_BAD;
    for (int p = 0; p < 5; p++) begin
      int len;
      len = (p == 0) ? 11 : (p == 1) ? 10 : (p == 2) ? 9 : (p == 3) ? 8 : 6;
      for (int j = 0; j < rules.size(); j++)
        if (id == I_BAD && rules[j].len == len && int'(ins >> (32 - len)) == rules[j].pat)
          id = rules[j].id;
    end
    return id;
  endfunction

  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit v, cy, n, z;
    v = f[3]; cy = f[2]; n = f[1]; z = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && n == v;
      4'd13: return z || n != v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic longint sext(input longint val, input int bits);
    if (val >= (64'sd1 <<< (bits - 1))) return val - (64'sd1 <<< bits);
    return val;
  endfunction

  function automatic void m_exec(input logic [31:0] ins, input logic [4:0] st,
                                 output logic [29:0] w, output logic [63:0] k);
    int id;
    logic en_pc, en_mem, en_alu, pcsel, bsel, sl, wm, wr;
    logic [1:0] ps;
    logic [4:0] fs, sb, sa, da;
    bit rtype, itype;
    id = m_decode(ins);
    {en_pc, en_mem, en_alu, pcsel, bsel, sl, wm, wr} = '0;
    fs = 0; sb = 0; sa = 0; da = 0; k = 0; ps = 2'b01;
    rtype = id inside {I_ADD, I_SUB, I_AND, I_ORR, I_EOR, I_ADDS, I_SUBS, I_LSL, I_LSR};
    itype = id inside {I_ADDI, I_SUBI, I_ANDI, I_ORRI, I_EORI, I_ADDIS, I_SUBIS};
    case (id)
      I_ADD, I_ADDS, I_ADDI, I_ADDIS, I_LDUR, I_STUR: fs = 5'b01000;
      I_SUB, I_SUBS, I_SUBI, I_SUBIS:                 fs = 5'b01001;
      I_ORR, I_ORRI, I_MOVZ, I_CBZ, I_CBNZ:           fs = 5'b00100;
      I_EOR, I_EORI:                                  fs = 5'b01100;
      I_LSL:                                          fs = 5'b10000;
      I_LSR:                                          fs = 5'b10100;
      default:                                        fs = 5'b00000;
    endcase
    sl = id inside {I_ADDS, I_SUBS, I_ADDIS, I_SUBIS};
    if (rtype || itype) begin
      en_alu = 1; wr = 1; sa = ins[9:5]; da = ins[4:0];
    end
    if (rtype) sb = ins[20:16];
    if (id == I_LSL || id == I_LSR) begin bsel = 1; k = 64'(ins[15:10]); end
    if (itype) begin bsel = 1; k = 64'(ins[21:10]); end
    case (id)
      I_MOVZ: begin
        en_alu = 1; wr = 1; sa = 31; da = ins[4:0]; bsel = 1;
        k = 64'(ins[20:5]) << (16 * int'(ins[22:21]));
      end
      I_LDUR: begin
        sa = ins[9:5]; bsel = 1; k = sext(longint'(ins[20:12]), 9);
        en_mem = 1; wr = 1; da = ins[4:0];
      end
      I_STUR: begin
        sa = ins[9:5]; bsel = 1; k = sext(longint'(ins[20:12]), 9);
        sb = ins[4:0]; wm = 1;
      end
      I_B: begin
        pcsel = 1; ps = 2'b11; k = sext(longint'(ins[25:0]), 26) * 4;
      end
      I_CBZ, I_CBNZ: begin
        sa = 31; sb = ins[4:0]; pcsel = 1; k = sext(longint'(ins[23:5]), 19) * 4;
        ps = ((id == I_CBZ && st[0]) || (id == I_CBNZ && !st[0])) ? 2'b11 : 2'b01;
      end
      I_BCOND: begin
        pcsel = 1; k = sext(longint'(ins[23:5]), 19) * 4;
        ps = m_cond(ins[3:0], st[4:1]) ? 2'b11 : 2'b01;
      end
      I_BR: begin sa = ins[9:5]; ps = 2'b10; end
      I_BL: begin en_pc = 1; wr = 1; da = 30; ps = 2'b00; end
      I_BAD: ps = 2'b00;
      default: ;
    endcase
    w = {en_pc, en_mem, en_alu, pcsel, bsel, sl, wm, wr, ps, fs, sb, sa, da};
  endfunction

  // Compare the current cycle against the model, then advance both across one edge.
  task automatic tick();
    logic [29:0] ew;
    logic [63:0] ek;
    @(negedge clock);
    s_word  = control_word;
    s_const = constant;
    s_halt  = halted;
    if (m_valid) begin
      ew = '0;
      ek = '0;
      if (m_phase == 1) m_exec(m_ir, status, ew, ek);
      else if (m_phase == 2) begin
        ew = 30'd0 | (30'd1 << 26) | (30'd3 << 20);
        ek = sext(longint'(m_ir[25:0]), 26) * 4;
      end
      chk("control_word", 64'(control_word), 64'(ew));
      chk("constant", constant, ek);
      chk("halted", 64'(halted), 64'(m_phase == 3));
      chk("single_bus_enable", 64'($countones(control_word[29:27]) <= 1), 64'd1);
    end
    @(posedge clock);
    if (reset) begin
      m_phase = 0; m_ir = 0; m_valid = 1;
    end else begin
      case (m_phase)
        0: begin m_ir = instruction; m_phase = 1; end
        1: m_phase = (m_decode(m_ir) == I_BAD) ? 3 : (m_decode(m_ir) == I_BL) ? 2 : 0;
        2: m_phase = 0;
        default: m_phase = 3;
      endcase
    end
    #1;
  endtask

  task automatic run(input logic [31:0] ins, input logic [4:0] st);
    instruction = ins;
    status      = st;
    tick();
    tick();
  endtask

  logic [31:0] alu_vec[12] = '{
    {11'b10101010000, 5'd11, 6'd0, 5'd10, 5'd9},
    {11'b11001011000, 5'd4, 6'd0, 5'd5, 5'd6},
    {11'b10001010000, 5'd7, 6'd0, 5'd8, 5'd31},
    {11'b11001010000, 5'd1, 6'd0, 5'd2, 5'd3},
    {11'b10101011000, 5'd12, 6'd0, 5'd13, 5'd14},
    {11'b11101011000, 5'd15, 6'd0, 5'd16, 5'd17},
    {11'b11010011011, 5'd0, 6'd5, 5'd3, 5'd2},
    {11'b11010011010, 5'd0, 6'd63, 5'd4, 5'd1},
    {10'b1101001000, 12'hABC, 5'd6, 5'd7},
    {10'b1001000100, 12'hFFF, 5'd1, 5'd2},
    {10'b1001001000, 12'h0F0, 5'd3, 5'd4},
    {10'b1011000100, 12'h123, 5'd5, 5'd6}
  };

  initial begin
    add_rule(11, 'b10001011000, I_ADD);   add_rule(11, 'b11001011000, I_SUB);
    add_rule(11, 'b10001010000, I_AND);   add_rule(11, 'b10101010000, I_ORR);
    add_rule(11, 'b11001010000, I_EOR);   add_rule(11, 'b10101011000, I_ADDS);
    add_rule(11, 'b11101011000, I_SUBS);  add_rule(11, 'b11010011011, I_LSL);
    add_rule(11, 'b11010011010, I_LSR);   add_rule(11, 'b11111000010, I_LDUR);
    add_rule(11, 'b11111000000, I_STUR);  add_rule(11, 'b11010110000, I_BR);
    add_rule(10, 'b1001000100, I_ADDI);   add_rule(10, 'b1101000100, I_SUBI);
    add_rule(10, 'b1001001000, I_ANDI);   add_rule(10, 'b1011001000, I_ORRI);
    add_rule(10, 'b1101001000, I_EORI);   add_rule(10, 'b1011000100, I_ADDIS);
    add_rule(10, 'b1111000100, I_SUBIS);  add_rule(9, 'b110100101, I_MOVZ);
    add_rule(8, 'b10110100, I_CBZ);       add_rule(8, 'b10110101, I_CBNZ);
    add_rule(8, 'b01010100, I_BCOND);     add_rule(6, 'b000101, I_B);
    add_rule(6, 'b100101, I_BL);

    reset = 1'b1; instruction = '0; status = '0;
    tick();
    tick();
    chk("reset_word", 64'(s_word), 64'd0);
    chk("reset_const", s_const, 64'd0);
    chk("reset_halted", 64'(s_halt), 64'd0);
    reset = 1'b0;

    // ADD X3, X1, X2
    instruction = 32'h8B020023;
    tick();
    chk("add_fetch_word", 64'(s_word), 64'd0);
    tick();
    chk("add_exec_word", 64'(s_word), 64'h08540823);

    // SUBIS X0, X0, #1
    run(32'hF1000400, 5'd0);
    chk("subis_bsel", 64'(s_word[25]), 64'd1);
    chk("subis_sl", 64'(s_word[24]), 64'd1);
    chk("subis_const", s_const, 64'd1);
    chk("subis_fs", 64'(s_word[19:15]), 64'b01001);

    // LDUR X4, [X5, #-8]
    run(32'hF85F80A4, 5'd0);
    chk("ldur_const", s_const, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("ldur_en_mem", 64'(s_word[28]), 64'd1);
    chk("ldur_da", 64'(s_word[4:0]), 64'd4);

    // CBZ X7, #+16 taken / not taken
    run(32'hB4000087, 5'b00001);
    chk("cbz_taken_ps", 64'(s_word[21:20]), 64'd3);
    chk("cbz_const", s_const, 64'd16);
    chk("cbz_pcsel", 64'(s_word[26]), 64'd1);
    run(32'hB4000087, 5'b00000);
    chk("cbz_not_taken_ps", 64'(s_word[21:20]), 64'd1);
    run(32'hB5000087, 5'b00000);
    chk("cbnz_taken_ps", 64'(s_word[21:20]), 64'd3);

    // B.LT with V=1 (taken), V=0 (not); B.GT with Z=1 (not taken)
    run(32'h5400004B, 5'b10000);
    chk("blt_taken_ps", 64'(s_word[21:20]), 64'd3);
    chk("blt_const", s_const, 64'd8);
    run(32'h5400004B, 5'b00000);
    chk("blt_not_taken_ps", 64'(s_word[21:20]), 64'd1);
    run(32'h5400004C, 5'b00010);
    chk("bgt_z_not_taken_ps", 64'(s_word[21:20]), 64'd1);

    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f += 3)
        run(32'h54FFFFE0 | 32'(c), {4'(f), 1'b0});

    foreach (alu_vec[i]) run(alu_vec[i], 5'($urandom));

    // MOVZ X5, #0x1234, LSL #32
    run({9'b110100101, 2'd2, 16'h1234, 5'd5}, 5'd0);
    chk("movz_const", s_const, 64'h0000_1234_0000_0000);
    run({11'b11111000000, 9'd16, 2'b00, 5'd9, 5'd8}, 5'd0);
    chk("stur_wm", 64'(s_word[23]), 64'd1);
    run({11'b11010110000, 5'd31, 6'd0, 5'd30, 5'd0}, 5'd0);
    run({6'b000101, 26'd25}, 5'd0);
    chk("b_const", s_const, 64'd100);

    // BL #-4: EXEC, LINK, then FETCH
    run(32'h97FFFFFF, 5'd0);
    chk("bl_en_pc", 64'(s_word[29]), 64'd1);
    chk("bl_wr", 64'(s_word[22]), 64'd1);
    chk("bl_da", 64'(s_word[4:0]), 64'd30);
    chk("bl_ps", 64'(s_word[21:20]), 64'd0);
    instruction = 32'h8B020023;
    tick();
    chk("link_ps", 64'(s_word[21:20]), 64'd3);
    chk("link_const", s_const, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("after_link_word", 64'(s_word), 64'd0);
    tick();

    // Reset while in LINK discards the branch
    run(32'h97FFFFFF, 5'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    instruction = 32'h8B020023;
    tick();
    chk("reset_in_link_word", 64'(s_word), 64'd0);
    chk("reset_in_link_const", s_const, 64'd0);
    tick();

    // Unrecognised opcode halts until reset
    run(32'h00000000, 5'd0);
    chk("bad_exec_word", 64'(s_word), 64'd0);
    chk("bad_exec_halted", 64'(s_halt), 64'd0);
    for (int i = 0; i < 10; i++) begin
      instruction = $urandom;
      status      = 5'($urandom);
      tick();
      chk("halt_held", 64'(s_halt), 64'd1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    instruction = 32'h8B020023;
    tick();
    chk("halt_cleared", 64'(s_halt), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
